mips_fetch_stage: RTL



---
 rtl/mips_fetch_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mips_fetch_stage.sv
// ============================================================================
//  Module      : mips_fetch_stage
//  Description : Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the
//                PC, drives the combinational instruction-memory address and
//                captures the fetched word into the IF/ID pipeline register.
//                Handles stalls, branch/jump redirects with IF/ID flush and a
//                sticky halt that only reset clears.
//                Optional build macro: FETCH_PERF_CNT_EN adds saturating
//                perf_fetched / perf_stalls counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt_req,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
`endif
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [31:0] c_PC_STEP = 32'd4;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_ifid_instr;
    logic [31:0] w_ifid_instr_nxt;
    logic [31:0] r_ifid_pc4;
    logic [31:0] w_ifid_pc4_nxt;
    logic        r_ifid_valid;
    logic        w_ifid_valid_nxt;

    logic [31:0] w_pc_plus4;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_fetch_evt;
    logic        w_stall_evt;

    // Sequential PC wraps modulo 2^32; redirect targets are word-aligned by
    // clearing the two low bits, branch beating jump when both are asserted.
    assign w_pc_plus4    = r_pc + c_PC_STEP;
    assign w_redirect    = branch_taken | jump;
    assign w_redirect_pc = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;

    // State, PC and IF/ID register updates; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc4   <= w_ifid_pc4_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
        end
    end

    // Next-state logic: halt > redirect > stall > sequential fetch in RUN.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc4_nxt   = r_ifid_pc4;
        w_ifid_valid_nxt = r_ifid_valid;
        w_fetch_evt      = 1'b0;
        w_stall_evt      = 1'b0;

        case (r_state)
            S_BOOT: begin
                // One settling cycle with the PC held and IF/ID empty.
                w_state_nxt      = S_RUN;
                w_ifid_instr_nxt = NOP_WORD;
                w_ifid_pc4_nxt   = 32'd0;
                w_ifid_valid_nxt = 1'b0;
            end
            S_RUN: begin
                if (halt_req) begin
                    w_state_nxt      = S_HALTED;
                    w_ifid_instr_nxt = NOP_WORD;
                    w_ifid_pc4_nxt   = 32'd0;
                    w_ifid_valid_nxt = 1'b0;
                end else if (w_redirect) begin
                    // Flush the wrong-path word currently being fetched.
                    w_pc_nxt         = w_redirect_pc;
                    w_ifid_instr_nxt = NOP_WORD;
                    w_ifid_pc4_nxt   = 32'd0;
                    w_ifid_valid_nxt = 1'b0;
                end else if (stall) begin
                    w_stall_evt = 1'b1;
                end else begin
                    w_pc_nxt         = w_pc_plus4;
                    w_ifid_instr_nxt = imem_data;
                    w_ifid_pc4_nxt   = w_pc_plus4;
                    w_ifid_valid_nxt = 1'b1;
                    w_fetch_evt      = 1'b1;
                end
            end
            S_HALTED: begin
                w_ifid_instr_nxt = NOP_WORD;
                w_ifid_pc4_nxt   = 32'd0;
                w_ifid_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign imem_addr     = r_pc;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc_plus4 = r_ifid_pc4;
    assign ifid_valid    = r_ifid_valid;
    assign halted        = (r_state == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stalls;

    // Saturating event counters; events only fire in RUN so HALTED freezes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= 32'd0;
            r_perf_stalls  <= 32'd0;
        end else begin
            if (w_fetch_evt && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_stall_evt && (r_perf_stalls != 32'hFFFF_FFFF)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stalls  = r_perf_stalls;
`endif

endmodule

`default_nettype wire
